// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over a valid/ready handshake.
// Define AES_KS_REPLAY_EN to keep an 11-entry key store that can be re-emitted at one key per cycle.
module aes_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         replay,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

`ifdef AES_KS_REPLAY_EN
    typedef enum logic [2:0] {IDLE, EMIT, SUB, EXP, REPLAY} state_t;
`else
    typedef enum logic [2:0] {IDLE, EMIT, SUB, EXP} state_t;
`endif

    state_t       state;
    logic [7:0]   rcon;
    logic [31:0]  sub_p1;
    logic [31:0]  t_word;
    logic [127:0] next_key;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        t_word            = sub_p1 ^ {rcon, 24'h0};
        next_key          = '0;
        next_key[127:96]  = rk_out[127:96] ^ t_word;
        next_key[95:64]   = rk_out[95:64]  ^ next_key[127:96];
        next_key[63:32]   = rk_out[63:32]  ^ next_key[95:64];
        next_key[31:0]    = rk_out[31:0]   ^ next_key[63:32];
    end

`ifdef AES_KS_REPLAY_EN
    logic [127:0] store [0:10];
    logic         stored;

    always_ff @(posedge clk) begin
        if (state == EMIT && rk_ready) store[rk_idx] <= rk_out;
    end
`else
    logic unused_replay;
    assign unused_replay = replay;
`endif

    // rk_out doubles as the working key register W = {w0, w1, w2, w3}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rk_out   <= '0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rcon     <= 8'h01;
`ifdef AES_KS_REPLAY_EN
            stored   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_idx   <= 4'd0;
                        rcon     <= 8'h01;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= EMIT;
`ifdef AES_KS_REPLAY_EN
                        stored   <= 1'b0;
                    end else if (replay && stored) begin
                        rk_out   <= store[0];
                        rk_idx   <= 4'd0;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REPLAY;
`endif
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_idx == 4'd10) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`ifdef AES_KS_REPLAY_EN
                            stored <= 1'b1;
`endif
                        end else begin
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    sub_p1 <= sub_word({rk_out[23:0], rk_out[31:24]});
                    state  <= EXP;
                end
                EXP: begin
                    rk_out   <= next_key;
                    rk_idx   <= rk_idx + 4'd1;
                    rcon     <= xtime(rcon);
                    rk_valid <= 1'b1;
                    state    <= EMIT;
                end
`ifdef AES_KS_REPLAY_EN
                REPLAY: begin
                    if (rk_ready) begin
                        if (rk_idx == 4'd10) begin
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            rk_idx <= rk_idx + 4'd1;
                            rk_out <= store[rk_idx + 4'd1];
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboarded bench for aes_key_sched: FIPS-197 and all-zero keys, stalls, ignored start, mid-run reset, replay.
module tb_aes_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         replay;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    aes_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .replay(replay),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Reference model: byte-level GF arithmetic with brute-force inverse.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        return s ^ 8'h63;
    endfunction

    task automatic push_keys(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        exp_t        e;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {ref_sbox(tmp[31:24]), ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0])};
                tmp = tmp ^ {rc, 24'h0};
                rc  = ref_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) begin
            e.idx = 4'(k);
            e.key = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
            sb.push_back(e);
        end
    endtask

    // Monitor: scoreboard pop on handshake, stall stability, done/valid exclusivity.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) begin
                    checks++;
                    if (rk_valid) begin
                        errors++;
                        $display("FAIL done_with_valid: rk_valid=%0b required 0 while done", rk_valid);
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (rk_valid !== 1'b1 || rk_out !== prev_out || rk_idx !== prev_idx) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b idx=%0d out=%h required valid=1 idx=%0d out=%h",
                                 rk_valid, rk_idx, rk_out, prev_idx, prev_out);
                    end
                end
                if (rk_valid && rk_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_key: idx=%0d out=%h required no key", rk_idx, rk_out);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (rk_idx !== e.idx || rk_out !== e.key) begin
                            errors++;
                            $display("FAIL round_key: idx=%0d out=%h required idx=%0d out=%h",
                                     rk_idx, rk_out, e.idx, e.key);
                        end
                    end
                end
                prev_stall = rk_valid && !rk_ready;
                prev_out   = rk_out;
                prev_idx   = rk_idx;
            end
        end
    end

    task automatic do_start(input logic [127:0] key);
        @(posedge clk);
        #1 start = 1'b1;
        key_in = key;
        push_keys(key);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; replay = 1'b0; rk_ready = 1'b1; key_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rk_out !== '0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h idx=%0d valid=%0b busy=%0b done=%0b required all 0",
                     rk_out, rk_idx, rk_valid, busy, done);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_ignored: valid=%0b busy=%0b required 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips_timing;
        logic seen;
        seen = 1'b0;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (rk_valid) begin
                checks++;
                if (c != 1 + 3 * int'(rk_idx)) begin
                    errors++;
                    $display("FAIL key_timing: idx=%0d at cycle %0d required cycle %0d", rk_idx, c, 1 + 3 * int'(rk_idx));
                end
                if (rk_idx == 4'd1 || rk_idx == 4'd10) begin
                    checks++;
                    if (rk_out !== (rk_idx == 4'd1 ? 128'ha0fafe1788542cb123a339392a6c7605
                                                   : 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
                        errors++;
                        $display("FAIL fips_key: idx=%0d out=%h", rk_idx, rk_out);
                    end
                end
            end
            if (busy === 1'b0 && c < 32) begin
                checks++;
                errors++;
                $display("FAIL busy_early: busy=0 at cycle %0d required 1", c);
            end
            if (done) begin
                seen = 1'b1;
                checks++;
                if (c != 32 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing: cycle=%0d busy=%0b required cycle 32 busy 0", c, busy);
                end
            end
        end
        checks++;
        if (!seen || sb.size() != 0) begin
            errors++;
            $display("FAIL fips_complete: done_seen=%0b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        logic seen;
        seen = 1'b0;
        rk_ready = 1'b1;
        do_start('0);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (rk_valid && rk_idx == 4'd1) begin
                checks++;
                if (rk_out !== 128'h62636363626363636263636362636363) begin
                    errors++;
                    $display("FAIL zero_key1: out=%h required 62636363626363636263636362636363", rk_out);
                end
            end
            if (rk_valid && rk_idx == 4'd10) begin
                checks++;
                if (rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
                    errors++;
                    $display("FAIL zero_key10: out=%h required b4ef5bcb3e92e21123e951cf6f8f188e", rk_out);
                end
            end
            if (done) seen = 1'b1;
        end
        // Start presented in the done cycle must be taken on the very next edge.
        start = 1'b1;
        key_in = ALT_KEY;
        push_keys(ALT_KEY);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || rk_valid !== 1'b1 || rk_idx !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back: done_seen=%0b valid=%0b idx=%0d required 1 1 0", seen, rk_valid, rk_idx);
        end
        wait_done(60, seen);
        checks++;
        if (!seen || sb.size() != 0) begin
            errors++;
            $display("FAIL alt_complete: done_seen=%0b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_random_ready;
        logic seen;
        seen = 1'b0;
        rk_ready = 1'($urandom_range(0, 1));
        do_start(FIPS_KEY);
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk);
            #1 rk_ready = 1'($urandom_range(0, 1));
        end
        rk_ready = 1'b1;
        checks++;
        if (!seen || sb.size() != 0) begin
            errors++;
            $display("FAIL random_ready: done_seen=%0b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_start_ignored;
        logic seen;
        logic pulsed;
        seen = 1'b0;
        pulsed = 1'b0;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (rk_valid && rk_idx == 4'd5 && !pulsed) begin
                start = 1'b1;
                key_in = ALT_KEY;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || !pulsed || sb.size() != 0) begin
            errors++;
            $display("FAIL start_ignored: done_seen=%0b pulsed=%0b pending=%0d required 1 1 0",
                     seen, pulsed, sb.size());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: valid=%0b busy=%0b required 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        logic hit;
        hit = 1'b0;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (rk_valid && rk_idx == 4'd3) hit = 1'b1;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!hit || rk_out !== '0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hit=%0b out=%h idx=%0d valid=%0b busy=%0b done=%0b required 1 and all 0",
                     hit, rk_out, rk_idx, rk_valid, busy, done);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rk_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL reset_mid_quiet: valid=%0b required 0", rk_valid);
            end
        end
        do_start(FIPS_KEY);
        wait_done(60, seen);
        checks++;
        if (!seen || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_restart: done_seen=%0b pending=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_replay;
`ifdef AES_KS_REPLAY_EN
        logic seen;
        seen = 1'b0;
        rk_ready = 1'b1;
        @(posedge clk);
        #1 replay = 1'b1;
        push_keys(FIPS_KEY);
        @(posedge clk);
        #1 replay = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (c <= 11 && (rk_valid !== 1'b1 || rk_idx !== 4'(c - 1))) begin
                errors++;
                $display("FAIL replay_stream: cycle=%0d valid=%0b idx=%0d required 1 %0d", c, rk_valid, rk_idx, c - 1);
            end else if (c == 12 && done !== 1'b1) begin
                errors++;
                $display("FAIL replay_done: done=%0b required 1", done);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        replay = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL replay_after_reset: valid=%0b busy=%0b required 0 0", rk_valid, busy);
            end
        end
        replay = 1'b0;
        seen = sb.size() == 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL replay_pending: pending=%0d required 0", sb.size());
        end
`else
        rk_ready = 1'b1;
        @(posedge clk);
        #1 replay = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL replay_ignored: valid=%0b busy=%0b required 0 0", rk_valid, busy);
            end
        end
        replay = 1'b0;
`endif
    endtask

    initial begin
        test_reset;
        test_fips_timing;
        test_back_to_back;
        test_random_ready;
        test_start_ignored;
        test_reset_mid;
        test_replay;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
